level_from_edges: RTL and testbench

//   Rebuilds a clean level signal from 1-cycle rise/fall event pulses. It is the

---
 rtl/level_from_edges.sv | 128 ++++++++++++
 tb/tb_level_from_edges.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/level_from_edges.sv
// Rebuilds a clean level from 1-cycle rise/fall event pulses. Each new level is
// held for a programmable minimum number of cycles. One opposite request may be deferred.
module level_from_edges #(
    parameter int MIN_HIGH_P = 4,
    parameter int MIN_LOW_P  = 4,
    parameter int CNT_W_P    = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic rise_i,
    input  logic fall_i,
    output logic level_o,
    output logic busy_o,
    output logic pending_o,
    output logic err_o
);

    // Bit 1 of the encoding is the level and bit 0 marks a hold state, so both outputs come straight from flops.
    typedef enum logic [1:0] {
        LOW_SET   = 2'b00,
        LOW_HOLD  = 2'b01,
        HIGH_SET  = 2'b10,
        HIGH_HOLD = 2'b11
    } state_t;

    localparam logic [CNT_W_P-1:0] HIGH_LOAD = CNT_W_P'(MIN_HIGH_P - 1);
    localparam logic [CNT_W_P-1:0] LOW_LOAD  = CNT_W_P'(MIN_LOW_P - 1);

    if (MIN_HIGH_P < 1 || MIN_HIGH_P > (2 ** CNT_W_P)) begin : g_bad_min_high
        $error("MIN_HIGH_P must be in 1..2**CNT_W_P");
    end
    if (MIN_LOW_P < 1 || MIN_LOW_P > (2 ** CNT_W_P)) begin : g_bad_min_low
        $error("MIN_LOW_P must be in 1..2**CNT_W_P");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W_P-1:0]   r_cnt;
    logic [CNT_W_P-1:0]   w_cnt_next;
    logic                 r_pend;
    logic                 w_pend_next;
    logic                 r_err;
    logic                 w_err_next;
    logic                 w_pend_eff;

    logic                 w_both;
    logic                 w_toward;
    logic                 w_same;
    logic [CNT_W_P-1:0]   w_load;
    state_t               w_flip_state;
    state_t               w_set_state;

    // "toward" requests the opposite level, "same" re-requests the current one.
    assign w_both       = rise_i & fall_i;
    assign w_toward     = r_state[1] ? fall_i : rise_i;
    assign w_same       = r_state[1] ? rise_i : fall_i;
    assign w_load       = r_state[1] ? LOW_LOAD : HIGH_LOAD;
    assign w_flip_state = r_state[1] ? LOW_HOLD : HIGH_HOLD;
    assign w_set_state  = r_state[1] ? HIGH_SET : LOW_SET;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pend_next  = r_pend;
        w_err_next   = 1'b0;
        w_pend_eff   = r_pend;
        case (r_state)
            LOW_SET, HIGH_SET: begin
                if (w_both) begin
                    w_err_next = 1'b1;
                end else if (w_toward) begin
                    w_state_next = w_flip_state;
                    w_cnt_next   = w_load;
                    w_pend_next  = 1'b0;
                end else if (w_same) begin
                    w_err_next = 1'b1;
                end
            end
            LOW_HOLD, HIGH_HOLD: begin
                if (w_both) begin
                    w_err_next = 1'b1;
                end else begin
                    if (w_toward) begin
                        w_err_next = r_pend;
                        w_pend_eff = 1'b1;
                    end else if (w_same) begin
                        w_err_next = ~r_pend;
                        w_pend_eff = 1'b0;
                    end
                    if (r_cnt != '0) begin
                        w_cnt_next  = r_cnt - 1'b1;
                        w_pend_next = w_pend_eff;
                    end else if (w_pend_eff) begin
                        w_state_next = w_flip_state;
                        w_cnt_next   = w_load;
                        w_pend_next  = 1'b0;
                    end else begin
                        w_state_next = w_set_state;
                        w_pend_next  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next = LOW_SET;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= LOW_SET;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pend  <= w_pend_next;
            r_err   <= w_err_next;
        end
    end

    assign level_o   = r_state[1];
    assign busy_o    = r_state[0];
    assign pending_o = r_pend;
    assign err_o     = r_err;

endmodule

// File: tb/tb_level_from_edges.sv
// Bench for level_from_edges: a default instance and a MIN=1 instance share stimulus
// and are compared every cycle against an age/pending level model.
module tb_level_from_edges;

    logic clk;
    logic rst_n;
    logic rise;
    logic fall;

    logic lvl0, busy0, pend0, err0;
    logic lvl1, busy1, pend1, err1;

    int n_cmp = 0;
    int n_bad = 0;

    level_from_edges dut0 (
        .clk_i     (clk),
        .reset_i   (rst_n),
        .rise_i    (rise),
        .fall_i    (fall),
        .level_o   (lvl0),
        .busy_o    (busy0),
        .pending_o (pend0),
        .err_o     (err0)
    );

    level_from_edges #(.MIN_HIGH_P(1), .MIN_LOW_P(1), .CNT_W_P(8)) dut1 (
        .clk_i     (clk),
        .reset_i   (rst_n),
        .rise_i    (rise),
        .fall_i    (fall),
        .level_o   (lvl1),
        .busy_o    (busy1),
        .pending_o (pend1),
        .err_o     (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: age = cycles the current level has been held; the hold is active while age <= MIN.
    logic m_level [2];
    int   m_age   [2];
    logic m_pend  [2];
    logic m_err   [2];
    int   m_min   [2];

    initial begin
        m_min[0] = 4;
        m_min[1] = 1;
    end

    task automatic model_reset(input int k);
        m_level[k] = 1'b0;
        m_age[k]   = m_min[k] + 1;
        m_pend[k]  = 1'b0;
        m_err[k]   = 1'b0;
    endtask

    task automatic model_step(input int k);
        logic toward, same, p;
        int mn;
        mn     = m_min[k];
        toward = m_level[k] ? fall : rise;
        same   = m_level[k] ? rise : fall;
        m_err[k] = 1'b0;
        if (rise && fall) begin
            m_err[k] = 1'b1;
        end else if (m_age[k] > mn) begin
            if (toward) begin
                m_level[k] = ~m_level[k];
                m_age[k]   = 1;
                m_pend[k]  = 1'b0;
            end else if (same) begin
                m_err[k] = 1'b1;
            end
        end else begin
            p = m_pend[k];
            if (toward) begin
                if (p) m_err[k] = 1'b1;
                p = 1'b1;
            end else if (same) begin
                if (p) p = 1'b0;
                else   m_err[k] = 1'b1;
            end
            if (m_age[k] == mn) begin
                if (p) begin
                    m_level[k] = ~m_level[k];
                    m_age[k]   = 1;
                end else begin
                    m_age[k] = mn + 1;
                end
                m_pend[k] = 1'b0;
            end else begin
                m_age[k]  = m_age[k] + 1;
                m_pend[k] = p;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic chk(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("d0_level",   lvl0,  m_level[0]);
        chk("d0_busy",    busy0, m_age[0] <= m_min[0]);
        chk("d0_pending", pend0, m_pend[0]);
        chk("d0_err",     err0,  m_err[0]);
        chk("d1_level",   lvl1,  m_level[1]);
        chk("d1_busy",    busy1, m_age[1] <= m_min[1]);
        chk("d1_pending", pend1, m_pend[1]);
        chk("d1_err",     err1,  m_err[1]);
    end

    // Drives one cycle of inputs; returns 1ns into the next cycle.
    task automatic cyc(input logic r, input logic f);
        rise = r;
        fall = f;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rise  = 1'b0;
        fall  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level",   lvl0,  1'b0);
        chk("rst_busy",    busy0, 1'b0);
        chk("rst_pending", pend0, 1'b0);
        chk("rst_err",     err0,  1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rise  = 1'b0;
        fall  = 1'b0;

        // 1: single rise holds 4 cycles then settles high
        do_reset();
        cyc(1, 0);
        for (int k = 1; k <= 4; k++) begin
            chk("t1_level", lvl0, 1'b1);
            chk("t1_busy",  busy0, 1'b1);
            cyc(0, 0);
        end
        chk("t1_busy_c5",  busy0, 1'b0);
        chk("t1_level_c5", lvl0,  1'b1);
        $display("test1 rise/hold: level=%b busy=%b", lvl0, busy0);

        // 2: deferred fall takes effect after the high hold
        do_reset();
        cyc(1, 0);
        cyc(0, 1);
        chk("t2_pend_c2", pend0, 1'b1);
        cyc(0, 0);
        cyc(0, 0);
        cyc(0, 0);
        chk("t2_level_c5", lvl0,  1'b0);
        chk("t2_pend_c5",  pend0, 1'b0);
        for (int k = 5; k <= 8; k++) begin
            chk("t2_busy", busy0, 1'b1);
            cyc(0, 0);
        end
        chk("t2_busy_c9", busy0, 1'b0);
        $display("test2 deferred fall: level=%b busy=%b", lvl0, busy0);

        // 3: rise cancels the pending fall
        do_reset();
        cyc(1, 0);
        cyc(0, 1);
        cyc(1, 0);
        chk("t3_pend_c3",  pend0, 1'b0);
        chk("t3_err_c3",   err0,  1'b0);
        chk("t3_level_c3", lvl0,  1'b1);
        cyc(0, 0);
        cyc(0, 0);
        chk("t3_busy_c5",  busy0, 1'b0);
        chk("t3_level_c5", lvl0,  1'b1);
        $display("test3 glitch cancel: level=%b pending=%b", lvl0, pend0);

        // 4: coincident events and redundant fall
        do_reset();
        cyc(1, 1);
        chk("t4_err_both",  err0,  1'b1);
        chk("t4_level",     lvl0,  1'b0);
        chk("t4_busy",      busy0, 1'b0);
        cyc(0, 0);
        chk("t4_err_clear", err0,  1'b0);
        cyc(0, 1);
        chk("t4_err_fall",  err0,  1'b1);
        chk("t4_level2",    lvl0,  1'b0);
        $display("test4 errors: err=%b level=%b", err0, lvl0);

        // 5: MIN=1 instance follows 1,0,1
        do_reset();
        cyc(1, 0);
        chk("t5_level_c1", lvl1, 1'b1);
        cyc(0, 1);
        chk("t5_level_c2", lvl1, 1'b0);
        cyc(1, 0);
        chk("t5_level_c3", lvl1, 1'b1);
        $display("test5 min=1: level=%b", lvl1);

        // 6: asynchronous reset mid-hold
        do_reset();
        cyc(1, 0);
        cyc(0, 1);
        chk("t6_pend_pre", pend0, 1'b1);
        rise = 1'b0;
        fall = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_level_rst", lvl0,  1'b0);
        chk("t6_busy_rst",  busy0, 1'b0);
        chk("t6_pend_rst",  pend0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) cyc(0, 0);
        chk("t6_level_after", lvl0,  1'b0);
        chk("t6_busy_after",  busy0, 1'b0);
        $display("test6 async reset: level=%b busy=%b pending=%b", lvl0, busy0, pend0);

        // Random traffic with varying event density and occasional mid-cycle resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int dens;
            dens = (i < 1000) ? 3 : ((i < 2000) ? 1 : 6);
            if ($urandom_range(0, 299) == 0) begin
                rise = 1'b0;
                fall = 1'b0;
                #2;
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end else begin
                cyc($urandom_range(0, dens) == 0, $urandom_range(0, dens) == 0);
            end
            if (i % 500 == 499)
                $display("random cycle %0d: level0=%b level1=%b", i + 1, lvl0, lvl1);
        end

        rise = 1'b0;
        fall = 1'b0;
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
